// File: rtl/move_cmd_queue.sv
// Direction-command front end: per-channel hold-off, pending slot, round-robin arbiter, FWFT FIFO.
// Optional drop counter output enabled with `define DROP_CNT_EN.
module move_cmd_queue #(
    parameter int N_CH    = 2,
    parameter int DEPTH   = 4,
    parameter int HOLDOFF = 50_000_000,
    localparam int SRC_W  = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_CH-1:0]     in_valid,
    input  logic [2*N_CH-1:0]   in_dir,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [1:0]          out_dir,
    output logic [SRC_W-1:0]    out_src,
    output logic [AW:0]         level,
`ifdef DROP_CNT_EN
    output logic [7:0]          drop_cnt,
`endif
    output logic                drop_pulse
);

    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam int EW = SRC_W + 2;
    localparam logic [HW-1:0] HLOAD = HW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
    localparam logic [HW-1:0] HONE  = HW'(1);

    logic [N_CH-1:0][HW-1:0]  hold_q, hold_d;
    logic [N_CH-1:0]          pend_v_q, pend_v_d;
    logic [N_CH-1:0][1:0]     pend_dir_q, pend_dir_d;
    logic [SRC_W-1:0]         rr_q, rr_d;
    logic [DEPTH-1:0][EW-1:0] mem_q;
    logic [AW:0]              wptr_q, wptr_d, rptr_q, rptr_d;
    logic                     drop_pulse_q;
`ifdef DROP_CNT_EN
    logic [7:0]               drop_cnt_q;
`endif

    logic [N_CH-1:0]  accept;
    logic [N_CH-1:0]  gnt_oh;
    logic             gnt_v;
    logic [SRC_W-1:0] gnt_idx;
    logic             drop_any;
    logic             full, pop, can_push;
    logic [EW-1:0]    head;
    int               arb_idx;

    assign out_valid = (wptr_q != rptr_q);
    assign full      = (wptr_q[AW] != rptr_q[AW]) &&
                       (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop       = out_valid && out_ready;
    assign can_push  = !full || pop;
    assign level     = wptr_q - rptr_q;
    assign head      = mem_q[rptr_q[AW-1:0]];
    assign out_dir   = head[1:0];
    assign out_src   = head[EW-1:2];
    assign drop_pulse = drop_pulse_q;
`ifdef DROP_CNT_EN
    assign drop_cnt  = drop_cnt_q;
`endif

    // First pending channel at or after the round-robin pointer wins
    always_comb begin
        gnt_v   = 1'b0;
        gnt_idx = '0;
        gnt_oh  = '0;
        arb_idx = 0;
        if (can_push) begin
            for (int k = 0; k < N_CH; k++) begin
                arb_idx = int'(rr_q) + k;
                if (arb_idx >= N_CH) arb_idx = arb_idx - N_CH;
                if (!gnt_v && pend_v_q[arb_idx]) begin
                    gnt_v   = 1'b1;
                    gnt_idx = SRC_W'(arb_idx);
                end
            end
        end
        gnt_oh[gnt_idx] = gnt_v;
    end

    always_comb begin
        accept     = '0;
        hold_d     = hold_q;
        pend_dir_d = pend_dir_q;
        for (int i = 0; i < N_CH; i++) begin
            accept[i] = in_valid[i] && (hold_q[i] == '0);
            if (accept[i]) begin
                hold_d[i]     = HLOAD;
                pend_dir_d[i] = in_dir[2*i +: 2];
            end else if (hold_q[i] != '0) begin
                hold_d[i] = hold_q[i] - HONE;
            end
        end
        // A granted slot leaves this cycle, so a new event there is not an overwrite
        drop_any = |(accept & pend_v_q & ~gnt_oh);
        pend_v_d = (pend_v_q & ~gnt_oh) | accept;
        rr_d     = rr_q;
        if (gnt_v) begin
            rr_d = (gnt_idx == SRC_W'(N_CH - 1)) ? '0 : gnt_idx + SRC_W'(1);
        end
        wptr_d = wptr_q + (AW+1)'(gnt_v);
        rptr_d = rptr_q + (AW+1)'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q       <= '0;
            pend_v_q     <= '0;
            pend_dir_q   <= '0;
            rr_q         <= '0;
            mem_q        <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            drop_pulse_q <= 1'b0;
`ifdef DROP_CNT_EN
            drop_cnt_q   <= '0;
`endif
        end else if (flush) begin
            hold_q       <= '0;
            pend_v_q     <= '0;
            rr_q         <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            drop_pulse_q <= 1'b0;
`ifdef DROP_CNT_EN
            drop_cnt_q   <= '0;
`endif
        end else begin
            hold_q       <= hold_d;
            pend_v_q     <= pend_v_d;
            pend_dir_q   <= pend_dir_d;
            rr_q         <= rr_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            drop_pulse_q <= drop_any;
            if (gnt_v) begin
                mem_q[wptr_q[AW-1:0]] <= {gnt_idx, pend_dir_q[gnt_idx]};
            end
`ifdef DROP_CNT_EN
            if (drop_any && drop_cnt_q != 8'hFF) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_move_cmd_queue.sv
// Randomised and directed bench for move_cmd_queue against a queue-based reference model.
// Runs with N_CH=2, DEPTH=4, HOLDOFF=4.
module tb_move_cmd_queue;

    localparam int N = 2;
    localparam int D = 4;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] in_valid;
    logic [3:0] in_dir;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_dir;
    logic       out_src;
    logic [2:0] level;
    logic       drop_pulse;
`ifdef DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_hold[N];
    bit m_pv[N];
    int m_pd[N];
    int m_rr;
    int m_q[$];
    bit m_drop;
    int m_dcnt;

    always #5 clk = ~clk;

    move_cmd_queue #(.N_CH(N), .DEPTH(D), .HOLDOFF(H)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_dir(in_dir),
        .flush(flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_dir(out_dir),
        .out_src(out_src),
        .level(level),
`ifdef DROP_CNT_EN
        .drop_cnt(drop_cnt),
`endif
        .drop_pulse(drop_pulse)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_hold[i] = 0;
            m_pv[i] = 0;
            m_pd[i] = 0;
        end
        m_rr = 0;
        m_q.delete();
        m_drop = 0;
        m_dcnt = 0;
    endtask

    task automatic model_step(input logic [1:0] v, input logic [3:0] d,
                              input logic rdy, input logic fl);
        bit pop;
        bit drop;
        int g;
        int idx;
        if (fl) begin
            model_clear();
            return;
        end
        pop = (m_q.size() > 0) && rdy;
        g = -1;
        if (m_q.size() < D || pop) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_rr + k) % N;
                if (g < 0 && m_pv[idx]) g = idx;
            end
        end
        if (pop) void'(m_q.pop_front());
        if (g >= 0) begin
            m_q.push_back(g * 4 + m_pd[g]);
            m_pv[g] = 0;
            m_rr = (g + 1) % N;
        end
        drop = 0;
        for (int i = 0; i < N; i++) begin
            if (v[i] && m_hold[i] == 0) begin
                if (m_pv[i]) drop = 1;
                m_pv[i] = 1;
                m_pd[i] = (d >> (2 * i)) & 3;
                m_hold[i] = (H > 0) ? H - 1 : 0;
            end else if (m_hold[i] > 0) begin
                m_hold[i]--;
            end
        end
        m_drop = drop;
        if (drop && m_dcnt < 255) m_dcnt++;
    endtask

    task automatic check_model();
        chk("valid", out_valid, m_q.size() > 0);
        chk("level", level, m_q.size());
        chk("drop", drop_pulse, m_drop);
        if (m_q.size() > 0) begin
            chk("dir", out_dir, m_q[0] & 3);
            chk("src", out_src, m_q[0] >> 2);
        end
`ifdef DROP_CNT_EN
        chk("dcnt", drop_cnt, m_dcnt);
`endif
    endtask

    task automatic cyc(input logic [1:0] v, input logic [3:0] d,
                       input logic rdy, input logic fl);
        @(negedge clk);
        in_valid  = v;
        in_dir    = d;
        out_ready = rdy;
        flush     = fl;
        @(posedge clk);
        model_step(v, d, rdy, fl);
        #1;
        check_model();
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cyc(2'b00, 4'h0, rdy, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = '0;
        in_dir = '0;
        flush = 1'b0;
        out_ready = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_dir", out_dir, 0);
        chk("rst_src", out_src, 0);
        chk("rst_drop", drop_pulse, 0);
`ifdef DROP_CNT_EN
        chk("rst_dcnt", drop_cnt, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Single command latency
        cyc(2'b01, 4'b0010, 1'b0, 1'b0);
        cyc(2'b00, 4'h0, 1'b0, 1'b0);
        chk("t1_valid", out_valid, 1);
        chk("t1_dir", out_dir, 2'b10);
        chk("t1_src", out_src, 0);
        chk("t1_level", level, 1);
        idle(6, 1'b1);

        // Same-cycle pair, then round robin favours ch1
        cyc(2'b00, 4'h0, 1'b1, 1'b1);
        cyc(2'b11, 4'b1101, 1'b1, 1'b0);
        cyc(2'b00, 4'h0, 1'b1, 1'b0);
        chk("t2_first_dir", out_dir, 2'b01);
        chk("t2_first_src", out_src, 0);
        cyc(2'b00, 4'h0, 1'b1, 1'b0);
        chk("t2_second_dir", out_dir, 2'b11);
        chk("t2_second_src", out_src, 1);
        idle(5, 1'b1);
        cyc(2'b01, 4'b0000, 1'b1, 1'b0);
        idle(5, 1'b1);
        cyc(2'b11, 4'b1001, 1'b1, 1'b0);
        cyc(2'b00, 4'h0, 1'b1, 1'b0);
        chk("t2_rr_src", out_src, 1);
        chk("t2_rr_dir", out_dir, 2'b10);
        idle(5, 1'b1);

        // Fill the FIFO, then overwrite the stuck pending entry
        cyc(2'b00, 4'h0, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            cyc(2'b01, 4'((k == 5) ? 3 : k % 4), 1'b0, 1'b0);
            if (k == 5) chk("t3_drop", drop_pulse, 1);
            idle(3, 1'b0);
        end
        chk("t3_level", level, 4);
        chk("t3_head", out_dir, 0);

        // Pop and write in the same edge
        cyc(2'b00, 4'h0, 1'b1, 1'b0);
        chk("t5_level", level, 4);
        chk("t5_head", out_dir, 1);

        // Flush with level 3 and a same-cycle ch1 strobe
        cyc(2'b00, 4'h0, 1'b1, 1'b0);
        chk("t6_pre_level", level, 3);
        cyc(2'b10, 4'b0100, 1'b0, 1'b1);
        chk("t6_level", level, 0);
        chk("t6_valid", out_valid, 0);
        idle(3, 1'b0);
        chk("t6_no_pend", out_valid, 0);

        // Hold-off window: strobes at 0, 2, 4
        cyc(2'b01, 4'b0001, 1'b1, 1'b0);
        cyc(2'b00, 4'h0, 1'b1, 1'b0);
        cyc(2'b01, 4'b0010, 1'b1, 1'b0);
        cyc(2'b00, 4'h0, 1'b1, 1'b0);
        cyc(2'b01, 4'b0011, 1'b0, 1'b0);
        chk("t4_nodrop", drop_pulse, 0);
        cyc(2'b00, 4'h0, 1'b0, 1'b0);
        chk("t4_level", level, 1);
        chk("t4_dir", out_dir, 2'b11);
        idle(4, 1'b1);

        // Randomised traffic with varying back-pressure
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] v;
            logic rdy;
            logic fl;
            v = 2'($urandom_range(0, 3));
            if (($urandom % 3) == 0) v = 2'b00;
            case ((i / 300) % 3)
                0: rdy = ($urandom % 4) != 0;
                1: rdy = ($urandom % 6) == 0;
                default: rdy = ($urandom % 2) == 0;
            endcase
            fl = ($urandom % 150) == 0;
            cyc(v, 4'($urandom), rdy, fl);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
